subarray_mac_ctrl: RTL and testbench
====================================

Name: subarray_mac_ctrl

Overview:
- Sequencer for one near-memory MAC subarray.
- On a start request it latches the input vector, clears the accumulator, and steps wordlines through a contiguous row range, with wrap-around inside the subarray.
- It issues accumulate-enables aligned to the fixed datapath latency, then signals completion.
- Sits between the tile-level command decoder and the subarray MAC datapath registers.

Parameters:
- ROW_NUM, 64, number of rows in the subarray (power of two).
- ROW_AW, 6, row address width, equal to log2(ROW_NUM).
- ACC_LAT, 2, cycles from wl_en asserted to the partial sum being valid at the accumulator input (≥1).

Ports:
- sys_clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sys_en  in  1  global clock-enable; low freezes all state.
- start  in  1  operation request, sampled in IDLE only.
- row_base  in  ROW_AW  first row of the operation.
- row_cnt  in  ROW_AW+1  number of rows, legal range 1..ROW_NUM.
- busy  out  1  high whenever state is not IDLE.
- in_en  out  1  load strobe for the datapath input-vector register.
- acc_clr  out  1  accumulator clear strobe.
- wl_en  out  1  wordline enable.
- wl_addr  out  ROW_AW  wordline address, valid while wl_en is high.
- acc_en  out  1  accumulate strobe.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, all counters 0.
  - busy, in_en, acc_clr, wl_en, wl_addr, acc_en, done, err all 0.
  - Reset asserted mid-operation aborts immediately. No done is issued, and no stale acc_en appears after release.
- sys_en=0:
  - State, counters and the acc_en delay pipe hold their values.
  - All strobes (in_en, acc_clr, wl_en, acc_en, done, err) are forced to 0.
  - busy and wl_addr hold.
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE:
  - On start=1 with sys_en=1:
    - If row_cnt==0 or row_cnt>ROW_NUM: err=1 for the next cycle and state stays IDLE.
    - Otherwise latch row_base and row_cnt and go to LOAD.
- LOAD:
  - One cycle with in_en=1 and acc_clr=1.
  - Then go to RUN with row index idx=0.
- RUN:
  - wl_en=1, wl_addr=(base+idx) mod ROW_NUM. Natural ROW_AW-bit wrap, so base=62, cnt=4 gives 62,63,0,1.
  - idx increments each enabled cycle.
  - When idx==cnt-1, go to DRAIN.
- acc_en is wl_en delayed by exactly ACC_LAT enabled cycles. There is one acc_en per row.
- DRAIN:
  - Lasts ACC_LAT enabled cycles, until the last acc_en has been issued.
  - Then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Timing, with start sampled at edge 0 and all cycles enabled:
  - LOAD in cycle 1.
  - wl_en in cycles 2..cnt+1.
  - acc_en in cycles 2+ACC_LAT..cnt+1+ACC_LAT.
  - done in cycle cnt+2+ACC_LAT.
  - Total latency is cnt+ACC_LAT+2 cycles.
- Start handling:
  - start while busy is ignored; no error and no queueing.
  - start in the same cycle as done is ignored. A new start is accepted no earlier than the first IDLE cycle.
- row_base and row_cnt are don't-care outside the start-acceptance cycle.
- busy is 1 from cycle 1 through the done cycle inclusive.

Decomposition:
- Shared package mac_ctrl_pkg holds:
  - the state enum,
  - the default ROW_NUM, ROW_AW and ACC_LAT values,
  - a function giving the row_cnt legality check.
- One sub-module, mac_en_pipe: an ACC_LAT-deep, 1-bit shift register with sys_en hold and async clear. It generates acc_en from wl_en.

Test Plan:
- Basic run: ACC_LAT=2, start with base=5, cnt=4 -> in_en/acc_clr in cycle 1; wl_addr 5,6,7,8 in cycles 2–5; acc_en in cycles 4–7; done in cycle 8; busy 1–8.
- Wrap: base=62, cnt=4 -> wl_addr 62,63,0,1; exactly 4 acc_en pulses.
- Illegal count: start with cnt=0, then with cnt=65 -> err pulse one cycle after each; busy stays 0; no wl_en.
- Stall: base=0, cnt=3, with sys_en=0 for 3 cycles during the second wl_en -> strobes 0 while stalled; sequence resumes at wl_addr=1; done delayed by exactly 3 cycles; acc_en count is 3.
- Reset mid-run: rst_n low during the third RUN cycle -> all outputs 0 asynchronously; no acc_en/done after release; a new start then runs normally.
- Start while busy and start coincident with done -> both ignored; the next start in IDLE gives a full, correct sequence.

Source files
------------

// File: rtl/mac_ctrl_pkg.sv
// rtl/mac_ctrl_pkg.sv - shared types, defaults and row-count check for the subarray MAC sequencer
package mac_ctrl_pkg;

   localparam int ROW_NUM_DEF = 64;
   localparam int ROW_AW_DEF  = 6;
   localparam int ACC_LAT_DEF = 2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // A row count is usable when it names at least one row and no more than the subarray holds.
   function automatic logic row_cnt_legal(input logic [31:0] cnt, input int unsigned row_num);
      return (cnt != 32'd0) && (cnt <= row_num);
   endfunction

endpackage

// File: rtl/mac_en_pipe.sv
// rtl/mac_en_pipe.sv - fixed-depth delay line turning wordline enables into accumulate enables
module mac_en_pipe
   import mac_ctrl_pkg::*;
#(
   parameter int DEPTH = ACC_LAT_DEF
) (
   input  logic sys_clk,
   input  logic rst_n,
   input  logic sys_en,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] sr;

   generate
      if (DEPTH == 1) begin : g_single
         // Single-stage delay; holds while the global enable is low.
         always_ff @(posedge sys_clk or negedge rst_n) begin
            if (!rst_n)      sr <= '0;
            else if (sys_en) sr <= din;
         end
      end else begin : g_multi
         // Shift one stage per enabled cycle; cleared on reset so an aborted run leaves no pulses behind.
         always_ff @(posedge sys_clk or negedge rst_n) begin
            if (!rst_n)      sr <= '0;
            else if (sys_en) sr <= {sr[DEPTH-2:0], din};
         end
      end
   endgenerate

   assign dout = sr[DEPTH-1];

endmodule

// File: rtl/subarray_mac_ctrl.sv
// rtl/subarray_mac_ctrl.sv - wordline/accumulate sequencer for one near-memory MAC subarray
module subarray_mac_ctrl
   import mac_ctrl_pkg::*;
#(
   parameter int ROW_NUM = ROW_NUM_DEF,
   parameter int ROW_AW  = ROW_AW_DEF,
   parameter int ACC_LAT = ACC_LAT_DEF
) (
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic              sys_en,
   input  logic              start,
   input  logic [ROW_AW-1:0] row_base,
   input  logic [ROW_AW:0]   row_cnt,
   output logic              busy,
   output logic              in_en,
   output logic              acc_clr,
   output logic              wl_en,
   output logic [ROW_AW-1:0] wl_addr,
   output logic              acc_en,
   output logic              done,
   output logic              err
);

   localparam int DW = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;
   localparam logic [ROW_AW:0] CNT_ONE   = 1;
   localparam logic [DW-1:0]   DRAIN_END = DW'(ACC_LAT - 1);

   state_t            state, state_nxt;
   logic [ROW_AW-1:0] base_q;
   logic [ROW_AW-1:0] idx_q;
   logic [ROW_AW:0]   cnt_q;
   logic [DW-1:0]     drain_q;
   logic              err_q;
   logic              accept, reject;
   logic              last_row, last_drain;
   logic              wl_raw, acc_raw;

   // Next-state decode and strobe generation; every strobe is masked by the global enable.
   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      reject     = 1'b0;
      last_row   = ({1'b0, idx_q} == (cnt_q - CNT_ONE));
      last_drain = (drain_q == DRAIN_END);
      wl_raw     = (state == S_RUN);
      case (state)
         S_IDLE: begin
            if (start) begin
               if (row_cnt_legal(32'(row_cnt), ROW_NUM)) begin
                  accept    = 1'b1;
                  state_nxt = S_LOAD;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         S_LOAD:  state_nxt = S_RUN;
         S_RUN:   if (last_row) state_nxt = S_DRAIN;
         S_DRAIN: if (last_drain) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      busy    = (state != S_IDLE);
      in_en   = sys_en & (state == S_LOAD);
      acc_clr = sys_en & (state == S_LOAD);
      wl_en   = sys_en & wl_raw;
      wl_addr = base_q + idx_q;
      acc_en  = sys_en & acc_raw;
      done    = sys_en & (state == S_DONE);
      err     = sys_en & err_q;
   end

   // State register; frozen while the global enable is low.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n)      state <= S_IDLE;
      else if (sys_en) state <= state_nxt;
   end

   // Operation registers: latched range, row index, drain counter and the delayed reject flag.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q  <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         drain_q <= '0;
         err_q   <= 1'b0;
      end else if (sys_en) begin
         err_q <= reject;
         if (accept) begin
            base_q <= row_base;
            cnt_q  <= row_cnt;
         end
         if (state == S_LOAD) idx_q <= '0;
         else if (state == S_RUN && !last_row) idx_q <= idx_q + ROW_AW'(1);
         if (state == S_RUN) drain_q <= '0;
         else if (state == S_DRAIN) drain_q <= drain_q + DW'(1);
      end
   end

   mac_en_pipe #(
      .DEPTH (ACC_LAT)
   ) u_en_pipe (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .sys_en  (sys_en),
      .din     (wl_raw),
      .dout    (acc_raw)
   );

endmodule

// File: tb/tb_subarray_mac_ctrl.sv
// tb/tb_subarray_mac_ctrl.sv - directed self-checking bench for subarray_mac_ctrl
module tb_subarray_mac_ctrl;

   localparam int ROW_NUM = 64;
   localparam int ROW_AW  = 6;
   localparam int ACC_LAT = 2;

   logic              sys_clk = 1'b0;
   logic              rst_n;
   logic              sys_en;
   logic              start;
   logic [ROW_AW-1:0] row_base;
   logic [ROW_AW:0]   row_cnt;
   logic              busy, in_en, acc_clr, wl_en, acc_en, done, err;
   logic [ROW_AW-1:0] wl_addr;

   int checks = 0;
   int errors = 0;

   subarray_mac_ctrl #(
      .ROW_NUM (ROW_NUM),
      .ROW_AW  (ROW_AW),
      .ACC_LAT (ACC_LAT)
   ) dut (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .sys_en   (sys_en),
      .start    (start),
      .row_base (row_base),
      .row_cnt  (row_cnt),
      .busy     (busy),
      .in_en    (in_en),
      .acc_clr  (acc_clr),
      .wl_en    (wl_en),
      .wl_addr  (wl_addr),
      .acc_en   (acc_en),
      .done     (done),
      .err      (err)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " busy"},    32'(busy),    0);
      chk({tag, " in_en"},   32'(in_en),   0);
      chk({tag, " acc_clr"}, 32'(acc_clr), 0);
      chk({tag, " wl_en"},   32'(wl_en),   0);
      chk({tag, " wl_addr"}, 32'(wl_addr), 0);
      chk({tag, " acc_en"},  32'(acc_en),  0);
      chk({tag, " done"},    32'(done),    0);
      chk({tag, " err"},     32'(err),     0);
   endtask

   // One full operation checked cycle by cycle against the documented timing.
   // stall_len cycles of sys_en=0 begin at cycle stall_at; poke re-asserts start while busy.
   task automatic run_op(input string tag, input int base, input int cnt,
                         input int stall_at, input int stall_len, input bit poke);
      int n_acc, n_wl, e, total;
      bit stalled;
      start = 1'b1; row_base = ROW_AW'(base); row_cnt = (ROW_AW+1)'(cnt); sys_en = 1'b1;
      step();
      start = 1'b0;
      n_acc = 0; n_wl = 0;
      total = cnt + ACC_LAT + 2 + stall_len;
      for (int c = 1; c <= total; c++) begin
         stalled = (stall_len > 0) && (c >= stall_at) && (c < stall_at + stall_len);
         sys_en = !stalled;
         e = (c < stall_at || stall_len == 0) ? c : (c - stall_len);
         #1;
         chk($sformatf("%s c%0d busy", tag, c), 32'(busy), 1);
         chk($sformatf("%s c%0d err", tag, c), 32'(err), 0);
         if (stalled) begin
            chk($sformatf("%s c%0d stall strobes", tag, c),
                32'({in_en, acc_clr, wl_en, acc_en, done}), 0);
            if (stall_at >= 2 && stall_at <= cnt + 1)
               chk($sformatf("%s c%0d stall wl_addr", tag, c),
                   32'(wl_addr), 32'((base + stall_at - 2) % ROW_NUM));
         end else begin
            chk($sformatf("%s c%0d in_en", tag, c),   32'(in_en),   32'(e == 1));
            chk($sformatf("%s c%0d acc_clr", tag, c), 32'(acc_clr), 32'(e == 1));
            chk($sformatf("%s c%0d wl_en", tag, c),   32'(wl_en),   32'(e >= 2 && e <= cnt + 1));
            if (e >= 2 && e <= cnt + 1)
               chk($sformatf("%s c%0d wl_addr", tag, c), 32'(wl_addr), 32'((base + e - 2) % ROW_NUM));
            chk($sformatf("%s c%0d acc_en", tag, c),
                32'(acc_en), 32'(e >= 2 + ACC_LAT && e <= cnt + 1 + ACC_LAT));
            chk($sformatf("%s c%0d done", tag, c), 32'(done), 32'(e == cnt + 2 + ACC_LAT));
         end
         if (acc_en) n_acc++;
         if (wl_en)  n_wl++;
         if (poke) begin
            start = 1'b1; row_base = 6'd40; row_cnt = 7'd2;
         end
         step();
      end
      start = 1'b0; sys_en = 1'b1;
      chk({tag, " acc_en count"}, 32'(n_acc), 32'(cnt));
      chk({tag, " wl_en count"},  32'(n_wl),  32'(cnt));
      chk({tag, " idle busy"},    32'(busy),  0);
      chk({tag, " idle err"},     32'(err),   0);
      step();
      chk({tag, " idle2 busy"},   32'(busy),  0);
      chk({tag, " idle2 in_en"},  32'(in_en), 0);
   endtask

   initial begin
      rst_n = 1'b0; sys_en = 1'b1; start = 1'b0; row_base = '0; row_cnt = '0;
      step(); step();
      chk_all_zero("reset");
      rst_n = 1'b1;
      step();
      chk_all_zero("post-reset idle");

      // Basic run.
      run_op("basic", 5, 4, 0, 0, 1'b0);

      // Wrap across the top of the subarray.
      run_op("wrap", 62, 4, 0, 0, 1'b0);

      // Single row and full subarray boundaries.
      run_op("cnt1", 17, 1, 0, 0, 1'b0);
      run_op("cnt64", 32, 64, 0, 0, 1'b0);

      // Illegal counts: rejected with one err pulse, no activity.
      start = 1'b1; row_base = 6'd3; row_cnt = 7'd0;
      step();
      start = 1'b0;
      chk("ill0 err", 32'(err), 1);
      chk("ill0 busy", 32'(busy), 0);
      chk("ill0 wl_en", 32'(wl_en), 0);
      step();
      chk("ill0 err clears", 32'(err), 0);
      chk("ill0 busy after", 32'(busy), 0);
      start = 1'b1; row_base = 6'd3; row_cnt = 7'd65;
      step();
      start = 1'b0;
      chk("ill65 err", 32'(err), 1);
      chk("ill65 busy", 32'(busy), 0);
      chk("ill65 wl_en", 32'(wl_en), 0);
      step();
      chk("ill65 err clears", 32'(err), 0);
      chk("ill65 busy after", 32'(busy), 0);
      chk("ill65 wl_en after", 32'(wl_en), 0);

      // Stall during the second wordline cycle.
      run_op("stall", 0, 3, 3, 3, 1'b0);

      // Reset during the third RUN cycle.
      start = 1'b1; row_base = 6'd10; row_cnt = 7'd5;
      step();
      start = 1'b0;
      step(); step(); step();
      chk("rst run3 wl_en", 32'(wl_en), 1);
      chk("rst run3 wl_addr", 32'(wl_addr), 12);
      rst_n = 1'b0;
      #1;
      chk_all_zero("async reset");
      step(); step();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("after reset %0d acc_en", i), 32'(acc_en), 0);
         chk($sformatf("after reset %0d done", i),   32'(done),   0);
         chk($sformatf("after reset %0d busy", i),   32'(busy),   0);
         step();
      end
      run_op("post-reset run", 20, 2, 0, 0, 1'b0);

      // Starts while busy and coincident with done are ignored; the next run is clean.
      run_op("poke", 50, 3, 0, 0, 1'b1);
      run_op("after poke", 7, 5, 0, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
